// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand loader: FSM encoding, frame header fields
// and the opcode values the ALU decodes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [3:0] HDR_SYNC = 4'hA;
    localparam logic [1:0] HDR_RSVD = 2'b00;

    localparam logic [1:0] OP_XOR = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_SUM = 2'd3;

    function automatic logic is_header(input logic [7:0] b);
        return (b[7:4] == HDR_SYNC) && (b[3:2] == HDR_RSVD);
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Byte-stream input and operand-set output of the loader, bundled for the ALU front end.
interface alu_operand_loader_if #(parameter int N_BITS = 32);

    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic [N_BITS-1:0] o_data_a;
    logic [N_BITS-1:0] o_data_b;
    logic [1:0]        o_operation;
    logic              o_valid;
    logic              o_frame_err;
    logic              o_timeout;
    logic              o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready, o_data_a, o_data_b, o_operation,
               o_valid, o_frame_err, o_timeout, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready, o_data_a, o_data_b, o_operation,
               o_valid, o_frame_err, o_timeout, o_busy
    );

endinterface

// File: rtl/byte_shift_assembler.sv
// Shadow register written one byte at a time at a given byte index; 'value' shows
// the register with this cycle's write already merged in.
module byte_shift_assembler #(
    parameter int N_BITS = 32,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [7:0]        data,
    output logic [N_BITS-1:0] value
);

    logic [N_BITS-1:0] value_q;

    // NOTE: assign the default first so every path drives 'value' and no latch is inferred.
    always_comb begin
        value = value_q;
        if (wr_en) begin
            for (int k = 0; k < N_BITS / 8; k++) begin
                if (idx == IDX_W'(k)) value[8*k +: 8] = data;
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     value_q <= '0;
        else if (clear) value_q <= '0;
        else            value_q <= value;
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Receives header + operand A + operand B as an LSB-first byte stream and issues
// them to the ALU as one registered operand set, with header checking and idle timeout.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int N_BITS      = 32,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    alu_operand_loader_if.slave  bus
);

    localparam int N_BYTES = N_BITS / 8;
    localparam int CW      = $clog2(N_BYTES) + 1;
    localparam int TW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TMO_EN  = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [CW-1:0]     byte_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [1:0]        op_sh;
    logic              transfer, hdr_ok, in_load, last_byte, tmo_hit;
    logic              shadow_clr, wr_a, wr_b;
    logic [N_BITS-1:0] a_value, b_value;

    always_comb begin
        transfer   = bus.i_rx_valid && bus.o_rx_ready;
        hdr_ok     = is_header(bus.i_rx_data);
        in_load    = (state == LOAD_A) || (state == LOAD_B);
        last_byte  = (byte_cnt == LAST_IDX);
        // A transfer on the would-be expiry cycle keeps the frame alive.
        tmo_hit    = TMO_EN && in_load && !transfer && (tmo_cnt == TMO_LAST);
        shadow_clr = ((state == IDLE) && transfer && hdr_ok) || tmo_hit;
        wr_a       = transfer && (state == LOAD_A);
        wr_b       = transfer && (state == LOAD_B);
    end

    byte_shift_assembler #(.N_BITS(N_BITS), .IDX_W(CW)) u_asm_a (
        .clk(i_clock), .rst_n(i_reset_n), .clear(shadow_clr), .wr_en(wr_a),
        .idx(byte_cnt), .data(bus.i_rx_data), .value(a_value)
    );

    byte_shift_assembler #(.N_BITS(N_BITS), .IDX_W(CW)) u_asm_b (
        .clk(i_clock), .rst_n(i_reset_n), .clear(shadow_clr), .wr_en(wr_b),
        .idx(byte_cnt), .data(bus.i_rx_data), .value(b_value)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            byte_cnt        <= '0;
            tmo_cnt         <= '0;
            op_sh           <= '0;
            bus.o_rx_ready  <= 1'b0;
            bus.o_data_a    <= '0;
            bus.o_data_b    <= '0;
            bus.o_operation <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_timeout   <= 1'b0;
            bus.o_busy      <= 1'b0;
        end else begin
            // Ready only drops for the ISSUE cycle; strobes default low.
            bus.o_rx_ready  <= 1'b1;
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_timeout   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (transfer) begin
                        if (hdr_ok) begin
                            state      <= LOAD_A;
                            op_sh      <= bus.i_rx_data[1:0];
                            byte_cnt   <= '0;
                            tmo_cnt    <= '0;
                            bus.o_busy <= 1'b1;
                        end else begin
                            bus.o_frame_err <= 1'b1;
                        end
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (transfer) begin
                        tmo_cnt <= '0;
                        if (!last_byte) begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end else begin
                            byte_cnt <= '0;
                            if (state == LOAD_A) begin
                                state <= LOAD_B;
                            end else begin
                                state           <= ISSUE;
                                bus.o_rx_ready  <= 1'b0;
                                bus.o_busy      <= 1'b0;
                                bus.o_valid     <= 1'b1;
                                bus.o_data_a    <= a_value;
                                bus.o_data_b    <= b_value;
                                bus.o_operation <= op_sh;
                            end
                        end
                    end else if (tmo_hit) begin
                        state         <= IDLE;
                        byte_cnt      <= '0;
                        tmo_cnt       <= '0;
                        op_sh         <= '0;
                        bus.o_busy    <= 1'b0;
                        bus.o_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ISSUE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: vector table of frames plus hand-built
// sequences for timeout, boundary, gaps, mid-frame reset and back-to-back frames.
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int N_BITS = 32;
    localparam int TMO    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_loader_if #(.N_BITS(N_BITS)) bus ();

    alu_operand_loader #(.N_BITS(N_BITS), .TIMEOUT_CYC(TMO)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Background monitors: ready must be low exactly when o_valid is high.
    bit mon_en      = 1'b0;
    int ready_err   = 0;
    int tmo_pulses  = 0;
    int valid_count = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_rx_ready !== !bus.o_valid) ready_err++;
            if (bus.o_timeout === 1'b1) tmo_pulses++;
        end
        if (bus.o_valid === 1'b1) valid_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] exp_a  = '0;
    logic [31:0] exp_b  = '0;
    logic [1:0]  exp_op = '0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, output int stalls);
        stalls = 0;
        bus.i_rx_data  = d;
        bus.i_rx_valid = 1'b1;
        while (bus.o_rx_ready !== 1'b1 && stalls < 20) begin
            step(1);
            stalls++;
        end
        if (stalls >= 20) check("rx_ready_wait", {63'd0, bus.o_rx_ready}, 64'd1);
        step(1);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [31:0] a, input logic [31:0] b, input int max_gap);
        int s;
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) step($urandom_range(0, max_gap));
            send_byte(a[8*k +: 8], s);
        end
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) step($urandom_range(0, max_gap));
            send_byte(b[8*k +: 8], s);
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] a,
                              input logic [31:0] b, input int max_gap);
        int s;
        send_byte(hdr, s);
        check("busy_after_hdr", {63'd0, bus.o_busy}, 64'd1);
        send_payload(a, b, max_gap);
    endtask

    // Called in the cycle right after the final B byte transfer.
    task automatic check_issue_now(input string name, input logic [31:0] a,
                                   input logic [31:0] b, input logic [1:0] op);
        check({name, "_valid"}, {63'd0, bus.o_valid}, 64'd1);
        check({name, "_ready_low"}, {63'd0, bus.o_rx_ready}, 64'd0);
        check({name, "_data_a"}, {32'd0, bus.o_data_a}, {32'd0, a});
        check({name, "_data_b"}, {32'd0, bus.o_data_b}, {32'd0, b});
        check({name, "_op"}, {62'd0, bus.o_operation}, {62'd0, op});
        exp_a  = a;
        exp_b  = b;
        exp_op = op;
    endtask

    task automatic check_issue(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] op);
        check_issue_now(name, a, b, op);
        step(1);
        check({name, "_valid_drop"}, {63'd0, bus.o_valid}, 64'd0);
        check({name, "_ready_back"}, {63'd0, bus.o_rx_ready}, 64'd1);
        check({name, "_hold_a"}, {32'd0, bus.o_data_a}, {32'd0, a});
    endtask

    task automatic check_held(input string name);
        check({name, "_hold_a"}, {32'd0, bus.o_data_a}, {32'd0, exp_a});
        check({name, "_hold_b"}, {32'd0, bus.o_data_b}, {32'd0, exp_b});
        check({name, "_hold_op"}, {62'd0, bus.o_operation}, {62'd0, exp_op});
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] a;
        logic [31:0] b;
        bit          good;
        logic [1:0]  op;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int s;
        int v0;

        vecs[0] = '{8'hA3, 32'h12345678, 32'h01020304, 1'b1, OP_SUM};
        vecs[1] = '{8'h55, 32'h0,        32'h0,        1'b0, OP_XOR};
        vecs[2] = '{8'hA0, 32'hFFFFFFFF, 32'h00000000, 1'b1, OP_XOR};
        vecs[3] = '{8'hA6, 32'h0,        32'h0,        1'b0, OP_XOR};
        vecs[4] = '{8'hA1, 32'hA5A5A5A5, 32'hA0A1A2A3, 1'b1, OP_AND};
        vecs[5] = '{8'hB2, 32'h0,        32'h0,        1'b0, OP_XOR};
        vecs[6] = '{8'hA2, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, OP_OR};

        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;

        // Reset state and ready rising on the first clock after release.
        step(3);
        check("rst_data_a", {32'd0, bus.o_data_a}, 64'd0);
        check("rst_data_b", {32'd0, bus.o_data_b}, 64'd0);
        check("rst_op", {62'd0, bus.o_operation}, 64'd0);
        check("rst_strobes", {60'd0, bus.o_valid, bus.o_frame_err, bus.o_timeout, bus.o_busy}, 64'd0);
        check("rst_ready", {63'd0, bus.o_rx_ready}, 64'd0);
        rst_n = 1'b1;
        check("rel_ready_still_low", {63'd0, bus.o_rx_ready}, 64'd0);
        step(1);
        check("rel_ready_rise", {63'd0, bus.o_rx_ready}, 64'd1);
        mon_en = 1'b1;

        // Table of frames and bad headers.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].good) begin
                send_frame(vecs[i].hdr, vecs[i].a, vecs[i].b, 0);
                check_issue($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op);
            end else begin
                send_byte(vecs[i].hdr, s);
                check($sformatf("vec%0d_frame_err", i), {63'd0, bus.o_frame_err}, 64'd1);
                check($sformatf("vec%0d_busy", i), {63'd0, bus.o_busy}, 64'd0);
                check($sformatf("vec%0d_no_valid", i), {63'd0, bus.o_valid}, 64'd0);
                check_held($sformatf("vec%0d", i));
                step(1);
                check($sformatf("vec%0d_err_drop", i), {63'd0, bus.o_frame_err}, 64'd0);
            end
        end

        // Timeout after two A bytes and ten idle cycles.
        send_byte(8'hA0, s);
        send_byte(8'h11, s);
        send_byte(8'h22, s);
        step(9);
        check("tmo_not_yet", {63'd0, bus.o_timeout}, 64'd0);
        check("tmo_busy_pre", {63'd0, bus.o_busy}, 64'd1);
        step(1);
        check("tmo_pulse", {63'd0, bus.o_timeout}, 64'd1);
        check("tmo_busy_fall", {63'd0, bus.o_busy}, 64'd0);
        check("tmo_no_valid", {63'd0, bus.o_valid}, 64'd0);
        check_held("tmo");
        step(1);
        check("tmo_drop", {63'd0, bus.o_timeout}, 64'd0);
        send_frame(8'hA1, 32'h0BADF00D, 32'h00C0FFEE, 0);
        check_issue("post_tmo", 32'h0BADF00D, 32'h00C0FFEE, OP_AND);

        // Transfer on the would-be expiry cycle wins.
        send_byte(8'hA2, s);
        send_byte(8'h33, s);
        step(9);
        send_byte(8'h44, s);
        check("edge_no_tmo", {63'd0, bus.o_timeout}, 64'd0);
        check("edge_busy", {63'd0, bus.o_busy}, 64'd1);
        send_byte(8'h55, s);
        send_byte(8'h66, s);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] bw;
            bw = 32'h89ABCDEF;
            send_byte(bw[8*k +: 8], s);
        end
        check_issue("edge", 32'h66554433, 32'h89ABCDEF, OP_OR);

        // Random gaps below the timeout give the same result as the gap-free frame.
        send_frame(8'hA3, 32'h12345678, 32'h01020304, 5);
        check_issue("gaps", 32'h12345678, 32'h01020304, OP_SUM);

        // Back-to-back frames with valid held high: header stalls through ISSUE.
        send_frame(8'hA1, 32'hF0E1D2C3, 32'h0000FFFF, 0);
        check_issue_now("b2b1", 32'hF0E1D2C3, 32'h0000FFFF, OP_AND);
        send_byte(8'hA0, s);
        check("b2b_stall_cycles", s, 64'd1);
        check("b2b_busy", {63'd0, bus.o_busy}, 64'd1);
        send_payload(32'h13579BDF, 32'h2468ACE0, 0);
        check_issue("b2b2", 32'h13579BDF, 32'h2468ACE0, OP_XOR);

        // Reset after five frame bytes aborts the frame.
        send_byte(8'hA3, s);
        for (int k = 0; k < 4; k++) send_byte(8'h70 + 8'(k), s);
        mon_en = 1'b0;
        v0 = valid_count;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_a", {32'd0, bus.o_data_a}, 64'd0);
        check("mid_rst_data_b", {32'd0, bus.o_data_b}, 64'd0);
        check("mid_rst_op", {62'd0, bus.o_operation}, 64'd0);
        check("mid_rst_strobes", {60'd0, bus.o_valid, bus.o_frame_err, bus.o_timeout, bus.o_busy}, 64'd0);
        check("mid_rst_ready", {63'd0, bus.o_rx_ready}, 64'd0);
        step(3);
        check("mid_rst_no_valid", valid_count, v0);
        rst_n = 1'b1;
        step(1);
        check("mid_rst_ready_rise", {63'd0, bus.o_rx_ready}, 64'd1);
        mon_en = 1'b1;
        send_frame(8'hA2, 32'h00000001, 32'h80000000, 0);
        check_issue("post_rst", 32'h00000001, 32'h80000000, OP_OR);

        step(2);
        check("ready_only_in_issue", ready_err, 64'd0);
        check("timeout_pulse_count", tmo_pulses, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter N_BITS, default 32, operand width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter TIMEOUT_CYC, default 1000, idle cycles allowed between frame bytes; 0 disables the timeout.
REQ-003 i_clock  in  1  sole clock; all flops SHALL be clocked on its rising edge.
REQ-004 i_reset_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 i_rx_data  in  8  incoming byte.
REQ-006 i_rx_valid  in  1  i_rx_data is valid this cycle.
REQ-007 o_rx_ready  out  1  loader accepts a byte this cycle; a byte transfers only when i_rx_valid and o_rx_ready are both 1.
REQ-008 o_data_a  out  N_BITS  assembled operand A.
REQ-009 o_data_b  out  N_BITS  assembled operand B.
REQ-010 o_operation  out  2  operation code for the ALU.
REQ-011 o_valid  out  1  one-cycle strobe: the o_data_a, o_data_b and o_operation outputs carry a new operand set.
REQ-012 o_frame_err  out  1  one-cycle strobe: bad header byte was dropped.
REQ-013 o_timeout  out  1  one-cycle strobe: partial frame was aborted.
REQ-014 o_busy  out  1  high while a frame is partially received (LOAD_A or LOAD_B).

Function
REQ-015 Frame format: 1 header byte, then N_BITS/8 bytes of A (LSB first), then N_BITS/8 bytes of B (LSB first).
REQ-016 Header byte: bits[7:4] SHALL equal 4'hA, bits[3:2] SHALL equal 2'b00, and bits[1:0] carry the opcode.
REQ-017 FSM states: IDLE, LOAD_A, LOAD_B, ISSUE.
REQ-018 IDLE: on a valid header transfer, latch the opcode into a shadow register, clear the byte counter and go to LOAD_A.
REQ-019 IDLE: on an invalid header transfer, pulse o_frame_err for the next cycle and stay in IDLE.
REQ-020 LOAD_A and LOAD_B: each transfer writes byte index k into shadow bits [8k+7:8k] and increments k; after the last byte, go to LOAD_B or ISSUE respectively.
REQ-021 ISSUE lasts exactly one cycle: o_rx_ready=0; shadow A, B and op are copied to o_data_a, o_data_b and o_operation; o_valid=1 in the same cycle; next state is IDLE.
REQ-022 Latency: o_valid SHALL assert on the cycle immediately after the final B byte transfer.
REQ-023 o_data_a, o_data_b and o_operation SHALL change only in the ISSUE cycle and hold between frames.
REQ-024 o_rx_ready SHALL be 1 in IDLE, LOAD_A and LOAD_B, and 0 in ISSUE; it SHALL be a registered function of state only.
REQ-025 Timeout counter: cleared on every transfer and on entry to LOAD_A; increments each LOAD_A/LOAD_B cycle without a transfer.
REQ-026 When the timeout counter reaches TIMEOUT_CYC (TIMEOUT_CYC>0): pulse o_timeout, go to IDLE, leave the outputs unchanged, and discard the shadow contents.
REQ-027 If a transfer occurs in the same cycle the counter would reach TIMEOUT_CYC, the transfer SHALL win and no timeout occurs.
REQ-028 Header-pattern bytes received inside LOAD_A or LOAD_B SHALL be treated as data (no resync).
REQ-029 Byte counter width SHALL be clog2(N_BITS/8)+1; timeout counter width SHALL be clog2(TIMEOUT_CYC+1).

Reset
REQ-030 While i_reset_n=0: state=IDLE; o_data_a=0, o_data_b=0, o_operation=0; o_valid, o_frame_err, o_timeout and o_busy all 0; o_rx_ready=0; all counters and shadows cleared.
REQ-031 o_rx_ready SHALL rise on the first clock after reset release.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no o_valid strobe.

Structure
REQ-033 Shared package alu_pkg SHALL hold the FSM state encoding, the header constants (sync 4'hA, reserved 2'b00), and the opcode constants XOR=0, AND=1, OR=2, SUM=3, matching the ALU decode.
REQ-034 One sub-module, byte_shift_assembler, SHALL be instantiated twice (A and B); it performs the indexed byte write into an N_BITS register.
REQ-035 The outputs SHALL drive the ALU's operand, operation and valid inputs directly, with no glue logic.

Verification
REQ-036 N_BITS=32; send A3, 78 56 34 12, 04 03 02 01 back-to-back -> o_valid 1 cycle after the last byte; A=0x12345678, B=0x01020304, op=3.
REQ-037 Send header 0x55 -> o_frame_err pulses once; FSM stays IDLE; a following valid frame is issued correctly.
REQ-038 TIMEOUT_CYC=10; send A0 and 2 A-bytes, then idle 10 cycles -> o_timeout pulses, o_busy falls, outputs hold their prior values, and a new frame works.
REQ-039 Random i_rx_valid gaps under TIMEOUT_CYC -> no timeout; data identical to the gap-free case; o_rx_ready=0 exactly in the ISSUE cycle.
REQ-040 Pull i_reset_n low after 5 frame bytes -> all outputs 0 immediately, no o_valid; after release, a full frame issues normally.
REQ-041 Send two frames back-to-back with i_rx_valid held high -> the header byte offered in the ISSUE cycle is stalled one cycle, then accepted; both frames issue.
